// File: rtl/dem_rotation_selector_pkg.sv
// -----------------------------------------------------------------------------
// dem_rotation_selector_pkg
// Shared constants and types for the multibit DAC path.
//   OUTPUT_WIDTH   : quantizer code width
//   LFSR_INIT      : legacy dither LFSR reset value
//   dem_mode_e     : element-selection mode encoding
//   DEM_LFSR_POLY  : Fibonacci feedback mask, x^8+x^6+x^5+x^4+1
//   DEM_LFSR_SEED  : default seed for the DEM dither LFSR
// -----------------------------------------------------------------------------
package dem_rotation_selector_pkg;

  localparam int         OUTPUT_WIDTH = 3;
  localparam logic [7:0] LFSR_INIT    = 8'hFF;

  typedef enum logic [1:0] {
    DEM_THERM      = 2'd0,
    DEM_DWA        = 2'd1,
    DEM_DWA_DITHER = 2'd2,
    DEM_RSVD       = 2'd3
  } dem_mode_e;

  // Bit k-1 set for each term x^k (left-shifting Fibonacci, feedback into bit 0).
  localparam logic [7:0] DEM_LFSR_POLY = 8'hB8;
  localparam logic [7:0] DEM_LFSR_SEED = LFSR_INIT;

endpackage

// File: rtl/dem_rotation_selector_lfsr.sv
// -----------------------------------------------------------------------------
// dem_lfsr
// Fibonacci LFSR used as the dither source for rotated element selection.
// Shifts left once per step; feedback is the XOR of the POLY-masked state.
// An all-zero state (lockup) reloads SEED on the next step.
//   clk   : clock
//   rst   : asynchronous active-high reset, loads SEED
//   step  : advance one position this cycle
//   state : current register contents
//   bit0  : current LSB (dither bit before the step)
// -----------------------------------------------------------------------------
module dem_lfsr
  import dem_rotation_selector_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEM_LFSR_SEED),
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEM_LFSR_POLY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  output logic [WIDTH-1:0] state,
  output logic             bit0
);

  if (WIDTH < 2) begin : g_bad_width
    $error("dem_lfsr: WIDTH must be at least 2");
  end

  if (SEED == '0) begin : g_bad_seed
    $error("dem_lfsr: SEED must be non-zero");
  end

  logic fb;

  assign fb   = ^(state & POLY);
  assign bit0 = state[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
    end else if (step) begin
      if (state == '0) begin
        state <= SEED;
      end else begin
        state <= {state[WIDTH-2:0], fb};
      end
    end
  end

endmodule

// File: rtl/dem_rotation_selector.sv
// -----------------------------------------------------------------------------
// dem_rotation_selector
// Dynamic-element-matching selector between the quantizer and the unit-element
// switch array. Each accepted code becomes a registered NUM_ELEM-wide enable
// vector: static thermometer, DWA rotation, or LFSR-dithered DWA rotation.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   mode      : 0 thermometer, 1 DWA, 2 dithered DWA, 3 same as 1
//   in_valid  : code_in is a new sample (always accepted)
//   code_in   : unsigned quantizer level
//   out_valid : sel_out/ptr_out/sat updated this cycle
//   sel_out   : unit-element enables, bit i drives element i
//   ptr_out   : rotation pointer after the last accepted sample
//   sat       : last accepted code exceeded NUM_ELEM and was clamped
// -----------------------------------------------------------------------------
module dem_rotation_selector
  import dem_rotation_selector_pkg::*;
#(
  parameter int                    CODE_WIDTH = OUTPUT_WIDTH,
  parameter int                    NUM_ELEM   = 7,
  parameter int                    LFSR_WIDTH = 8,
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED  = LFSR_WIDTH'(DEM_LFSR_SEED),
  localparam int                   PTR_W      = $clog2(NUM_ELEM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic                  in_valid,
  input  logic [CODE_WIDTH-1:0] code_in,
  output logic                  out_valid,
  output logic [NUM_ELEM-1:0]   sel_out,
  output logic [PTR_W-1:0]      ptr_out,
  output logic                  sat
);

  // NW holds 0..NUM_ELEM; SW holds ptr + n + d, which can reach 2*NUM_ELEM.
  localparam int NW = PTR_W + 1;
  localparam int SW = PTR_W + 2;

  if (NUM_ELEM < 2 || NUM_ELEM > (2**CODE_WIDTH) + 8) begin : g_bad_num_elem
    $error("dem_rotation_selector: NUM_ELEM out of range");
  end

  function automatic logic [NW-1:0] clamp_code(input logic [CODE_WIDTH-1:0] code);
    if (int'(code) > NUM_ELEM) begin
      clamp_code = NW'(NUM_ELEM);
    end else begin
      clamp_code = NW'(code);
    end
  endfunction

  // Sum is below 2*NUM_ELEM+1, so two conditional subtracts always suffice.
  function automatic logic [PTR_W-1:0] wrap_ptr(input logic [SW-1:0] sum);
    logic [SW-1:0] s;
    s = sum;
    if (s >= SW'(NUM_ELEM)) begin
      s = s - SW'(NUM_ELEM);
    end
    if (s >= SW'(NUM_ELEM)) begin
      s = s - SW'(NUM_ELEM);
    end
    wrap_ptr = s[PTR_W-1:0];
  endfunction

  dem_mode_e               mode_p0;
  logic [NW-1:0]           n_p0;
  logic                    sat_p0;
  logic [NUM_ELEM-1:0]     therm_p0;
  logic [2*NUM_ELEM-1:0]   rot_p0;
  logic [NUM_ELEM-1:0]     dwa_p0;
  logic                    dith_p0;
  logic [SW-1:0]           sum_p0;
  logic [NUM_ELEM-1:0]     sel_nxt_p0;
  logic [PTR_W-1:0]        ptr_nxt_p0;
  logic                    lfsr_step;
  logic [LFSR_WIDTH-1:0]   lfsr_state;
  logic                    lfsr_bit0;

  logic                    vld_p1;
  logic [NUM_ELEM-1:0]     sel_p1;
  logic [PTR_W-1:0]        ptr_p1;
  logic                    sat_p1;

  dem_lfsr #(
    .WIDTH (LFSR_WIDTH),
    .SEED  (LFSR_SEED),
    .POLY  (LFSR_WIDTH'(DEM_LFSR_POLY))
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (lfsr_step),
    .state (lfsr_state),
    .bit0  (lfsr_bit0)
  );

  // ---- stage p0: clamp, mask generation, pointer update ----
  assign mode_p0   = dem_mode_e'(mode);
  assign n_p0      = clamp_code(code_in);
  assign sat_p0    = int'(code_in) > NUM_ELEM;
  assign lfsr_step = in_valid && (mode_p0 == DEM_DWA_DITHER);

  // A locked-up all-zero LFSR contributes no dither; it is reloaded on the step.
  assign dith_p0 = (mode_p0 == DEM_DWA_DITHER) && lfsr_bit0 && (|lfsr_state);
  assign sum_p0  = SW'(ptr_p1) + SW'(n_p0) + SW'(dith_p0);

  // Thermometer of n ones, rotated left by ptr; the upper half folds back
  // onto the lower half to wrap from element NUM_ELEM-1 to element 0.
  always_comb begin
    therm_p0 = '0;
    for (int i = 0; i < NUM_ELEM; i++) begin
      therm_p0[i] = (NW'(i) < n_p0);
    end
    rot_p0 = {{NUM_ELEM{1'b0}}, therm_p0} << ptr_p1;
    dwa_p0 = rot_p0[NUM_ELEM-1:0] | rot_p0[2*NUM_ELEM-1:NUM_ELEM];
  end

  always_comb begin
    sel_nxt_p0 = dwa_p0;
    ptr_nxt_p0 = wrap_ptr(sum_p0);
    case (mode_p0)
      DEM_THERM: begin
        sel_nxt_p0 = therm_p0;
        ptr_nxt_p0 = ptr_p1;
      end
      default: begin
        sel_nxt_p0 = dwa_p0;
        ptr_nxt_p0 = wrap_ptr(sum_p0);
      end
    endcase
  end

  // ---- stage p1: output registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      sel_p1 <= '0;
      ptr_p1 <= '0;
      sat_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        sel_p1 <= sel_nxt_p0;
        ptr_p1 <= ptr_nxt_p0;
        sat_p1 <= sat_p0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign sel_out   = sel_p1;
  assign ptr_out   = ptr_p1;
  assign sat       = sat_p1;

endmodule

// File: tb/tb_dem_rotation_selector.sv
module tb_dem_rotation_selector;

  localparam int NE = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0] mode7;
  logic       vld7;
  logic [2:0] code7;
  logic       ov7;
  logic [6:0] sel7;
  logic [2:0] ptr7;
  logic       sat7;

  logic [1:0] mode5;
  logic       vld5;
  logic [2:0] code5;
  logic       ov5;
  logic [4:0] sel5;
  logic [2:0] ptr5;
  logic       sat5;

  dem_rotation_selector #(.NUM_ELEM(7)) u_dut7 (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode7),
    .in_valid  (vld7),
    .code_in   (code7),
    .out_valid (ov7),
    .sel_out   (sel7),
    .ptr_out   (ptr7),
    .sat       (sat7)
  );

  dem_rotation_selector #(.NUM_ELEM(5)) u_dut5 (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode5),
    .in_valid  (vld5),
    .code_in   (code5),
    .out_valid (ov5),
    .sel_out   (sel5),
    .ptr_out   (ptr5),
    .sat       (sat5)
  );

  typedef struct {
    logic       vld;
    logic [1:0] mode;
    logic [2:0] code;
    logic [6:0] sel;
    logic [2:0] ptr;
    logic       sat;
  } vec_t;

  typedef struct {
    logic       vld;
    logic [6:0] sel;
    logic [2:0] ptr;
    logic       sat;
    int         n;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[9];

  int checks = 0;
  int errors = 0;

  int         m_ptr;
  logic [7:0] m_lfsr;
  logic [6:0] m_sel;
  logic       m_sat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_lfsr = 8'hFF;
    m_sel  = '0;
    m_sat  = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [1:0] md, input int code, output exp_t e);
    int n;
    int d;
    logic fb;
    n = (code > NE) ? NE : code;
    if (v) begin
      m_sat = (code > NE);
      m_sel = '0;
      if (md == 2'd0) begin
        for (int k = 0; k < n; k++) m_sel[k] = 1'b1;
      end else begin
        for (int k = 0; k < n; k++) m_sel[(m_ptr + k) % NE] = 1'b1;
        d = (md == 2'd2) ? int'(m_lfsr[0]) : 0;
        m_ptr = (m_ptr + n + d) % NE;
        if (md == 2'd2) begin
          fb = m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3];
          m_lfsr = (m_lfsr == 8'h00) ? 8'hFF : {m_lfsr[6:0], fb};
        end
      end
    end
    e.vld = v;
    e.sel = m_sel;
    e.ptr = 3'(m_ptr);
    e.sat = m_sat;
    e.n   = n;
  endtask

  task automatic apply7(input logic v, input logic [1:0] md, input logic [2:0] c,
                        input exp_t e, input string tag);
    exp_t got;
    vld7  = v;
    mode7 = md;
    code7 = c;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    vld7 = 1'b0;
    if (sb_q.size() == 0) begin
      chk({tag, " scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      got = sb_q.pop_front();
      chk({tag, " out_valid"}, 32'(ov7), 32'(got.vld));
      chk({tag, " sel_out"}, 32'(sel7), 32'(got.sel));
      chk({tag, " ptr_out"}, 32'(ptr7), 32'(got.ptr));
      chk({tag, " sat"}, 32'(sat7), 32'(got.sat));
    end
  endtask

  initial begin
    exp_t e;
    exp_t em;
    logic [2:0] c;

    tbl[0] = '{1'b1, 2'd1, 3'd3, 7'b0000111, 3'd3, 1'b0};
    tbl[1] = '{1'b1, 2'd1, 3'd2, 7'b0011000, 3'd5, 1'b0};
    tbl[2] = '{1'b1, 2'd1, 3'd4, 7'b1100011, 3'd2, 1'b0};
    tbl[3] = '{1'b0, 2'd1, 3'd0, 7'b1100011, 3'd2, 1'b0};
    tbl[4] = '{1'b1, 2'd0, 3'd5, 7'b0011111, 3'd2, 1'b0};
    tbl[5] = '{1'b1, 2'd1, 3'd2, 7'b0001100, 3'd4, 1'b0};
    tbl[6] = '{1'b1, 2'd1, 3'd0, 7'b0000000, 3'd4, 1'b0};
    tbl[7] = '{1'b1, 2'd1, 3'd7, 7'b1111111, 3'd4, 1'b0};
    tbl[8] = '{1'b1, 2'd3, 3'd1, 7'b0010000, 3'd5, 1'b0};

    rst   = 1'b1;
    mode7 = 2'd0; vld7 = 1'b0; code7 = '0;
    mode5 = 2'd0; vld5 = 1'b0; code5 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset sel7", 32'(sel7), 32'd0);
    chk("reset ptr7", 32'(ptr7), 32'd0);
    chk("reset ov7", 32'(ov7), 32'd0);
    chk("reset sat7", 32'(sat7), 32'd0);
    chk("reset sel5", 32'(sel5), 32'd0);
    chk("reset ov5", 32'(ov5), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table on the 7-element instance.
    for (int i = 0; i < 9; i++) begin
      model_step(tbl[i].vld, tbl[i].mode, int'(tbl[i].code), em);
      e.vld = tbl[i].vld;
      e.sel = tbl[i].sel;
      e.ptr = tbl[i].ptr;
      e.sat = tbl[i].sat;
      e.n   = em.n;
      apply7(tbl[i].vld, tbl[i].mode, tbl[i].code, e, $sformatf("tbl%0d", i));
    end

    // Dithered rotation, back-to-back, against the reference model.
    for (int i = 0; i < 20; i++) begin
      c = 3'($urandom_range(0, 7));
      model_step(1'b1, 2'd2, int'(c), e);
      apply7(1'b1, 2'd2, c, e, $sformatf("dith%0d", i));
      chk($sformatf("dith%0d popcount", i), 32'($countones(sel7)), 32'(e.n));
    end

    // Clamp and sat on the 5-element instance.
    vld5 = 1'b1; mode5 = 2'd1; code5 = 3'd7;
    @(posedge clk); #1;
    chk("ne5 clamp sel", 32'(sel5), 32'h1F);
    chk("ne5 clamp sat", 32'(sat5), 32'd1);
    chk("ne5 clamp ptr", 32'(ptr5), 32'd0);
    chk("ne5 clamp ov", 32'(ov5), 32'd1);
    code5 = 3'd2;
    @(posedge clk); #1;
    vld5 = 1'b0;
    chk("ne5 next sel", 32'(sel5), 32'b00011);
    chk("ne5 next sat", 32'(sat5), 32'd0);
    chk("ne5 next ptr", 32'(ptr5), 32'd2);

    // Asynchronous reset in the middle of a DWA stream.
    for (int i = 0; i < 3; i++) begin
      model_step(1'b1, 2'd1, 3, e);
      apply7(1'b1, 2'd1, 3'd3, e, $sformatf("pre_rst%0d", i));
    end
    vld7 = 1'b1; mode7 = 2'd1; code7 = 3'd3;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async rst sel7", 32'(sel7), 32'd0);
    chk("async rst ptr7", 32'(ptr7), 32'd0);
    chk("async rst ov7", 32'(ov7), 32'd0);
    chk("async rst sat5", 32'(sat5), 32'd0);
    vld7 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    model_reset();
    model_step(1'b1, 2'd1, 3, e);
    apply7(1'b1, 2'd1, 3'd3, e, "post_rst");
    chk("post_rst literal sel", 32'(sel7), 32'b0000111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
